// File: rtl/fadd_pkg.sv
// Shared definitions for the fadd datapath and its requester arbiter.
// Provides IEEE-754 single-precision field widths and a clog2 helper
// used to size requester tags.
package fadd_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fadd.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Handles zeros, subnormals, infinities and NaN (canonical quiet NaN out).
// Ports:
//   a, b : operands
//   sum  : a + b
module fadd
  import fadd_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  localparam int MW = MAN_W + 1;   // significand with hidden bit
  localparam int XW = MW + 3;      // plus guard, round, sticky
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [FP_W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic             sa, sb, sl, ss;
  logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, d;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic [MW-1:0]    ml, ms;
  logic [XW-1:0]    xl, xs, xs_al, mask, norm;
  logic [XW:0]      acc;
  logic [EXP_W+1:0] e_n;
  logic [MW:0]      rnd;
  logic             a_nan, b_nan, a_inf, b_inf, swap, eff_sub, up, found;
  int               lz, sh;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  always_comb begin
    a_nan = (ea == EXP_MAX) && (fa != '0);
    b_nan = (eb == EXP_MAX) && (fb != '0);
    a_inf = (ea == EXP_MAX) && (fa == '0);
    b_inf = (eb == EXP_MAX) && (fb == '0);

    // Order operands by magnitude so the subtraction below never goes negative.
    swap = {eb, fb} > {ea, fa};
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    fl = swap ? fb : fa;
    fs = swap ? fa : fb;
    ml = {el != '0, fl};
    ms = {es != '0, fs};
    // Subnormals share the exponent of the smallest normal.
    el_eff = (el == '0) ? EXP_W'(1) : el;
    es_eff = (es == '0) ? EXP_W'(1) : es;
    d = el_eff - es_eff;

    xl = {ml, 3'b000};
    xs = {ms, 3'b000};
    mask = ~({XW{1'b1}} << d);
    if (d >= EXP_W'(XW)) begin
      xs_al = {{(XW-1){1'b0}}, |ms};
    end else begin
      xs_al = (xs >> d) | {{(XW-1){1'b0}}, |(xs & mask)};
    end

    eff_sub = sl ^ ss;
    acc = eff_sub ? ({1'b0, xl} - {1'b0, xs_al}) : ({1'b0, xl} + {1'b0, xs_al});
    e_n = {2'b00, el_eff};
    lz = XW;
    sh = 0;
    found = 1'b0;
    if (acc[XW]) begin
      // Carry out of an addition: shift right one, folding the lost bit into sticky.
      norm = acc[XW:1] | {{(XW-1){1'b0}}, acc[0]};
      e_n = e_n + 1'b1;
    end else begin
      norm = acc[XW-1:0];
      for (int i = XW - 1; i >= 0; i--) begin
        if (!found && norm[i]) begin
          lz = XW - 1 - i;
          found = 1'b1;
        end
      end
      // Stop normalising at the smallest exponent; the result is then subnormal.
      sh = (lz < int'(e_n) - 1) ? lz : int'(e_n) - 1;
      norm = norm << sh;
      e_n = e_n - 10'(sh);
    end

    up = norm[2] && (norm[1] || norm[0] || norm[3]);
    rnd = {1'b0, norm[XW-1:3]} + {{MW{1'b0}}, up};
    if (rnd[MW]) begin
      rnd = rnd >> 1;
      e_n = e_n + 1'b1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sum = QNAN;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (rnd == '0) begin
      sum = {sa & sb, {(FP_W-1){1'b0}}};
    end else if (e_n >= 10'(EXP_MAX)) begin
      sum = {sl, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      sum = {sl, rnd[MW-1] ? e_n[EXP_W-1:0] : {EXP_W{1'b0}}, rnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick of one request. Search begins at ptr+1 and wraps.
// Ports:
//   req   : request vector
//   ptr   : index of the last winner
//   en    : grant allowed this cycle
//   grant : one-hot grant (zero when en is low or nothing requests)
//   idx   : encoded winner index (valid whenever any request is set)
module rr_arbiter
  import fadd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c[IDW-1:0];
      end
    end
    if (found && en) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fadd_rr_arbiter.sv
// Shares one fadd among NREQ requesters. A round-robin grant feeds an
// operand register (s1); the fadd result is captured in the result
// register (s2). Results carry the requester index and leave in grant order.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : per-requester handshake
//   req_a, req_b         : packed operands, requester i at [32*i +: 32]
//   res_valid/res_ready  : result handshake
//   res_data, res_id     : sum and originating requester
//   busy                 : any stage occupied
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready never waits on valid being stable for a cycle; valid may
// drop without a transfer and nothing changes. res_data/res_id hold while
// res_valid is high and res_ready is low.
module fadd_rr_arbiter
  import fadd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FP_W-1:0]      res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx, ptr, s1_id;
  logic            s1_valid, s2_adv, s1_adv, issue_ok, xfer;
  logic [FP_W-1:0] s1_a, s1_b, a_sel, b_sel, sum;

  assign s2_adv   = !res_valid || res_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // Reset is folded in so no requester sees ready while reset is held.
  assign issue_ok = rst_n && (!s1_valid || s2_adv);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (issue_ok),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign busy      = s1_valid || res_valid;
  assign a_sel     = req_a[int'(win_idx)*FP_W +: FP_W];
  assign b_sel     = req_b[int'(win_idx)*FP_W +: FP_W];

  fadd u_fadd (
    .a   (s1_a),
    .b   (s1_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (xfer) begin
      ptr <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= a_sel;
      s1_b     <= b_sel;
      s1_id    <= win_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (s1_adv) begin
      res_valid <= 1'b1;
      res_data  <= sum;
      res_id    <= s1_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fadd_rr_arbiter.sv
module tb_fadd_rr_arbiter;
  import fadd_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*FP_W-1:0] req_a, req_b;
  logic                 res_valid, res_ready, busy;
  logic [FP_W-1:0]      res_data;
  logic [IDW-1:0]       res_id;

  fadd_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    check({name, "_len"}, got.size(), want.size());
    for (int k = 0; k < want.size(); k++)
      check(name, (k < got.size()) ? got[k] : -1, want[k]);
  endtask

  // ---------------- reference model ----------------
  // Expected sum of whatever operands each requester currently presents.
  logic [31:0]    exp_sum [NREQ];
  // In-flight ops in grant order; the flag says it has reached the output.
  logic [31:0]    exp_q[$];
  logic [IDW-1:0] eid_q[$];
  bit             out_q[$];
  int             m_ptr = NREQ - 1;
  int             grant_log[$];
  int             res_log[$];
  logic [31:0]    dat_log[$];

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] exp_ready;
    bit vis;
    int pop, win, c;
    if (!rst_n) begin
      m_ptr = NREQ - 1;
      exp_q.delete();
      eid_q.delete();
      out_q.delete();
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_id", res_id, 0);
    end else begin
      vis = (exp_q.size() > 0) && out_q[0];
      pop = (vis && res_ready) ? 1 : 0;
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[c]) win = c;
      end
      // Two ops fit in flight; a drain this cycle frees a slot.
      exp_ready = '0;
      if (win >= 0 && (exp_q.size() - pop) < 2) exp_ready[win] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("res_valid", res_valid, vis);
      check("busy", busy, exp_q.size() > 0);
      if (vis) begin
        check("res_data", res_data, exp_q[0]);
        check("res_id", res_id, eid_q[0]);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (res_valid && res_ready) begin
        res_log.push_back(int'(res_id));
        dat_log.push_back(res_data);
      end
      if (pop == 1) begin
        void'(exp_q.pop_front());
        void'(eid_q.pop_front());
        void'(out_q.pop_front());
      end
      if (exp_q.size() > 0 && !out_q[0]) out_q[0] = 1'b1;
      if (exp_ready != '0) begin
        exp_q.push_back(exp_sum[win]);
        eid_q.push_back(IDW'(win));
        out_q.push_back(1'b0);
        m_ptr = win;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    exp_sum[i] = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    res_log.delete();
    dat_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int want[$];
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_sum[i] = '0;
    tick(2);
    rst_n = 1'b1;
    check("reset_res_valid", res_valid, 0);
    check("reset_busy", busy, 0);

    // Single request: result 2 edges after the grant.
    set_req(0, 32'h4A3600CA, 32'hC93C97A8, 32'h4A06DAE0);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t1_lat1_res_valid", res_valid, 0);
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 32'h4A06DAE0);
    check("t1_res_id", res_id, 0);
    tick(2);

    // All requesters valid, full throughput.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h498AD804, 32'hCA1EF022, 32'hC9B30840);
    clear_logs();
    req_valid = '1;
    tick(8);
    req_valid = '0;
    tick(4);
    want = {0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("t2_grants", grant_log, want);
    check_seq("t2_res_ids", res_log, want);
    for (int k = 0; k < 8; k++)
      check("t2_data", (k < dat_log.size()) ? dat_log[k] : 32'h0, 32'hC9B30840);

    // Backpressure, plus requester 2 dropping valid without a handshake.
    do_reset();
    clear_logs();
    res_ready = 1'b0;
    set_req(2, 32'h4AA46873, 32'h49CDA038, 32'h4AD7D081);
    req_valid = 4'b0100;
    tick();
    set_req(1, 32'hC9D532B0, 32'h490C91C1, 32'hC98EE9D0);
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 2) ? 4'b0100 : 4'b0000;
      #1;
      check("t3_stall_ready", req_ready, 0);
      check("t3_stall_valid", res_valid, 1);
      check("t3_stall_data", res_data, 32'h4AD7D081);
      check("t3_stall_id", res_id, 2);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("t3_drain_data", res_data, 32'h4AD7D081);
    tick();
    check("t3_next_valid", res_valid, 1);
    check("t3_next_data", res_data, 32'hC98EE9D0);
    check("t3_next_id", res_id, 1);
    tick(3);
    want = {2, 1};
    check_seq("t3_res_ids", res_log, want);
    // Pointer still on 1, so 2 wins first.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h498AD804, 32'hCA1EF022, 32'hC9B30840);
    clear_logs();
    req_valid = '1;
    tick(4);
    req_valid = '0;
    tick(4);
    want = {2, 3, 0, 1};
    check_seq("t3_ptr_grants", grant_log, want);

    // Fairness between requesters 1 and 3.
    do_reset();
    set_req(1, 32'hC9D532B0, 32'h490C91C1, 32'hC98EE9D0);
    set_req(3, 32'h498AD804, 32'hCA1EF022, 32'hC9B30840);
    clear_logs();
    req_valid = 4'b1010;
    tick(4);
    req_valid = '0;
    tick(4);
    want = {1, 3, 1, 3};
    check_seq("t4_grants", grant_log, want);
    check_seq("t4_res_ids", res_log, want);
    check("t4_data0", (dat_log.size() > 0) ? dat_log[0] : 32'h0, 32'hC98EE9D0);
    check("t4_data1", (dat_log.size() > 1) ? dat_log[1] : 32'h0, 32'hC9B30840);

    // Reset with both stages full.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h498AD804, 32'hCA1EF022, 32'hC9B30840);
    res_ready = 1'b0;
    req_valid = '1;
    tick(3);
    check("t5_full_busy", busy, 1);
    check("t5_full_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", res_valid, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", req_ready, 0);
    check("t5_async_data", res_data, 0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    clear_logs();
    tick(4);
    req_valid = '0;
    tick(4);
    want = {0, 1, 2, 3};
    check_seq("t5_grants", grant_log, want);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
